// File: rtl/dtbdm_window_gen.sv
// 3x3 neighbourhood generator for the DTBDM de-noiser: two line buffers plus a
// shifting window array; emits one registered window per interior centre pixel.
module dtbdm_window_gen #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iSof,
    input  logic       iPixelValid,
    input  logic [7:0] iv8Pixel,
    output logic       oDataValid,
    output logic [7:0] ov8Pixel_a,
    output logic [7:0] ov8Pixel_b,
    output logic [7:0] ov8Pixel_c,
    output logic [7:0] ov8Pixel_d,
    output logic [7:0] ov8Pixel_fij,
    output logic [7:0] ov8Pixel_e,
    output logic [7:0] ov8Pixel_f,
    output logic [7:0] ov8Pixel_g,
    output logic [7:0] ov8Pixel_h,
    output logic [9:0] ov10Row,
    output logic [9:0] ov10Col,
    output logic       oFrameDone
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [9:0] LAST_COL = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] LAST_ROW = 10'(IMG_HEIGHT - 1);

    logic [9:0] c_q, c_d, r_q, r_d;
    logic [9:0] cur_c, cur_r;
    logic       accept, emit, frame_end;
    logic [7:0] lb1_rd, lb2_rd;

    logic [7:0] lb1_q [IMG_WIDTH];
    logic [7:0] lb2_q [IMG_WIDTH];

    // Window layout: 0..2 top (a,b,c), 3..5 middle (d,fij,e), 6..8 bottom (f,g,h)
    logic [7:0] win_q [9];
    logic [9:0] row_q, col_q;
    logic       valid_q, done_q;

    // A start-of-frame pixel is (0,0) whatever the counters say.
    always_comb begin
        accept    = iPixelValid;
        cur_c     = iSof ? 10'd0 : c_q;
        cur_r     = iSof ? 10'd0 : r_q;
        lb1_rd    = lb1_q[cur_c[AW-1:0]];
        lb2_rd    = lb2_q[cur_c[AW-1:0]];
        emit      = accept && (cur_r >= 10'd2) && (cur_c >= 10'd2);
        frame_end = (cur_r == LAST_ROW) && (cur_c == LAST_COL);
        c_d       = c_q;
        r_d       = r_q;
        if (accept) begin
            if (cur_c == LAST_COL) begin
                c_d = 10'd0;
                r_d = (cur_r == LAST_ROW) ? 10'd0 : cur_r + 10'd1;
            end else begin
                c_d = cur_c + 10'd1;
                r_d = cur_r;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            c_q <= 10'd0;
            r_q <= 10'd0;
        end else begin
            c_q <= c_d;
            r_q <= r_d;
        end
    end

    // Line buffers need no reset: rows 0 and 1 of every frame rewrite them
    // before any window can reference them.
    always_ff @(posedge iClk) begin
        if (accept) begin
            lb2_q[cur_c[AW-1:0]] <= lb1_rd;
            lb1_q[cur_c[AW-1:0]] <= iv8Pixel;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int i = 0; i < 9; i++) win_q[i] <= 8'd0;
            row_q   <= 10'd0;
            col_q   <= 10'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= emit;
            done_q  <= emit && frame_end;
            if (accept) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb2_rd;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb1_rd;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= iv8Pixel;
            end
            if (emit) begin
                row_q <= cur_r - 10'd1;
                col_q <= cur_c - 10'd1;
            end
        end
    end

    assign oDataValid   = valid_q;
    assign oFrameDone   = done_q;
    assign ov10Row      = row_q;
    assign ov10Col      = col_q;
    assign ov8Pixel_a   = win_q[0];
    assign ov8Pixel_b   = win_q[1];
    assign ov8Pixel_c   = win_q[2];
    assign ov8Pixel_d   = win_q[3];
    assign ov8Pixel_fij = win_q[4];
    assign ov8Pixel_e   = win_q[5];
    assign ov8Pixel_f   = win_q[6];
    assign ov8Pixel_g   = win_q[7];
    assign ov8Pixel_h   = win_q[8];

endmodule

// File: tb/tb_dtbdm_window_gen.sv
// Bench for dtbdm_window_gen: a 5x4 and a 3x3 instance, image-based window model,
// expected-window queues checked as the DUT emits.
module tb_dtbdm_window_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       sof5, v5, sof3, v3;
    logic [7:0] px5, px3;

    logic       dv5, done5, dv3, done3;
    logic [7:0] a5, b5, c5, d5, fij5, e5, f5, g5, h5;
    logic [7:0] a3, b3, c3, d3, fij3, e3, f3, g3, h3;
    logic [9:0] row5, col5, row3, col3;

    dtbdm_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) dut5 (
        .iClk(clk), .iRst(rst_n), .iSof(sof5), .iPixelValid(v5), .iv8Pixel(px5),
        .oDataValid(dv5), .ov8Pixel_a(a5), .ov8Pixel_b(b5), .ov8Pixel_c(c5),
        .ov8Pixel_d(d5), .ov8Pixel_fij(fij5), .ov8Pixel_e(e5),
        .ov8Pixel_f(f5), .ov8Pixel_g(g5), .ov8Pixel_h(h5),
        .ov10Row(row5), .ov10Col(col5), .oFrameDone(done5)
    );

    dtbdm_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .iClk(clk), .iRst(rst_n), .iSof(sof3), .iPixelValid(v3), .iv8Pixel(px3),
        .oDataValid(dv3), .ov8Pixel_a(a3), .ov8Pixel_b(b3), .ov8Pixel_c(c3),
        .ov8Pixel_d(d3), .ov8Pixel_fij(fij3), .ov8Pixel_e(e3),
        .ov8Pixel_f(f3), .ov8Pixel_g(g3), .ov8Pixel_h(h3),
        .ov10Row(row3), .ov10Col(col3), .oFrameDone(done3)
    );

    // Packed window: {row, col, a, b, c, d, fij, e, f, g, h, done}
    logic [92:0] obs5, obs3;
    assign obs5 = {row5, col5, a5, b5, c5, d5, fij5, e5, f5, g5, h5, done5};
    assign obs3 = {row3, col3, a3, b3, c3, d3, fij3, e3, f3, g3, h3, done3};

    logic [92:0] exp_q[$];
    logic [92:0] exp3_q[$];
    logic [7:0]  img [0:3][0:4];
    int n_checks = 0;
    int n_err = 0;
    int active = 0;
    int win_cnt = 0;
    int done_cnt = 0;
    logic vp5 = 1'b0, vp3 = 1'b0;

    task automatic check(input string tag, input logic [92:0] obs, input logic [92:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [92:0] make_exp(input int which, input int r, input int c);
        int w, h;
        logic dn;
        w  = (which == 0) ? 5 : 3;
        h  = (which == 0) ? 4 : 3;
        dn = (r == h - 1) && (c == w - 1);
        return {10'(r - 1), 10'(c - 1),
                img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                img[r][c-2],   img[r][c-1],   img[r][c], dn};
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        vp5 <= v5;
        vp3 <= v3;
    end

    task automatic mon(input int which, input logic [92:0] obs, input logic dv,
                       input logic done, input logic vprev);
        logic [92:0] e;
        if (!vprev) check("gap_dv", {92'b0, dv}, 93'd0);
        if (done && !dv) check("done_without_dv", {92'b0, done}, 93'd0);
        if (dv) begin
            win_cnt++;
            if (done) done_cnt++;
            if (which == 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("window5", obs, e);
            end else if (which == 1 && exp3_q.size() > 0) begin
                e = exp3_q.pop_front();
                check("window3", obs, e);
            end else begin
                check("unexpected_window", {92'b0, dv}, 93'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (active == 0) mon(0, obs5, dv5, done5, vp5);
            else             mon(1, obs3, dv3, done3, vp3);
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_px(input int which, input bit sof, input int r, input int c,
                            input logic [7:0] v);
        img[r][c] = v;
        if (which == 0) begin sof5 = sof; v5 = 1'b1; px5 = v; end
        else            begin sof3 = sof; v3 = 1'b1; px3 = v; end
        if (r >= 2 && c >= 2) begin
            if (which == 0) exp_q.push_back(make_exp(which, r, c));
            else            exp3_q.push_back(make_exp(which, r, c));
        end
        @(posedge clk);
        #1;
        v5 = 1'b0; sof5 = 1'b0; v3 = 1'b0; sof3 = 1'b0;
        px5 = 8'($urandom_range(0, 255));
        px3 = 8'($urandom_range(0, 255));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input int which, input bit sof, input int base, input bit gaps);
        int w, h, k;
        w = (which == 0) ? 5 : 3;
        h = (which == 0) ? 4 : 3;
        k = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (gaps && (k % 3 == 2)) idle(3);
                drive_px(which, sof && r == 0 && c == 0, r, c, 8'(base + 10 * r + c));
                k++;
            end
        end
    endtask

    task automatic drain_and_count(input string tag, input int which, input int wins,
                                   input int dones);
        int left;
        for (int i = 0; i < 20; i++) begin
            left = (which == 0) ? exp_q.size() : exp3_q.size();
            if (left == 0) break;
            @(negedge clk);
        end
        idle(2);
        left = (which == 0) ? exp_q.size() : exp3_q.size();
        check({tag, "_pending"}, 93'(left), 93'd0);
        check({tag, "_windows"}, 93'(win_cnt), 93'(wins));
        check({tag, "_frame_done"}, 93'(done_cnt), 93'(dones));
        win_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out5"}, obs5, 93'd0);
        check({tag, "_dv5"}, {92'b0, dv5}, 93'd0);
        check({tag, "_out3"}, obs3, 93'd0);
        check({tag, "_dv3"}, {92'b0, dv3}, 93'd0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        rst_n = 1'b0;
        sof5 = 1'b0; v5 = 1'b0; px5 = 8'd0;
        sof3 = 1'b0; v3 = 1'b0; px3 = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        active = 0;
        run_frame(0, 1'b1, 0, 1'b0);
        drain_and_count("basic", 0, 6, 1);

        run_frame(0, 1'b1, 0, 1'b1);
        drain_and_count("gaps", 0, 6, 1);

        run_frame(0, 1'b1, 0, 1'b0);
        run_frame(0, 1'b1, 100, 1'b0);
        drain_and_count("back_to_back", 0, 12, 2);

        // Reset in the middle of row 2, then restart without start-of-frame
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 5; c++) drive_px(0, r == 0 && c == 0, r, c, 8'(60 + 10 * r + c));
        drive_px(0, 1'b0, 2, 0, 8'd80);
        drive_px(0, 1'b0, 2, 1, 8'd81);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        run_frame(0, 1'b0, 0, 1'b0);
        drain_and_count("after_reset", 0, 6, 1);

        // Start-of-frame arriving at pixel (2,1) of a running frame
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 5; c++) drive_px(0, r == 0 && c == 0, r, c, 8'(50 + 10 * r + c));
        drive_px(0, 1'b0, 2, 0, 8'd70);
        run_frame(0, 1'b1, 200, 1'b0);
        drain_and_count("sof_restart", 0, 6, 1);

        active = 1;
        idle(2);
        run_frame(1, 1'b1, 0, 1'b0);
        drain_and_count("tiny_3x3", 1, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dtbdm_window_gen.md
# dtbdm_window_gen

Builds the 3x3 neighbourhood stream consumed by the DTBDM decision-tree de-noising stage. Accepts a raster-order 8-bit grayscale pixel stream, buffers the two previous image rows, and emits one registered 3x3 window per interior centre pixel, using the nine-pixel port layout the de-noiser expects. Sits between the frame source (Nios II DMA / pixel FIFO) and the de-noising top.

## Interface
- IMG_WIDTH, 320, pixels per row; legal range 3..1024.
- IMG_HEIGHT, 240, rows per frame; legal range 3..1024.
- iClk  in  1  single clock, rising edge.
- iRst  in  1  asynchronous, active-low reset.
- iSof  in  1  start of frame; qualifies the pixel on the same cycle as (row 0, col 0).
- iPixelValid  in  1  an input pixel is accepted on every cycle this is high; no backpressure.
- iv8Pixel  in  8  input pixel.
- oDataValid  out  1  window outputs are valid this cycle; drives the de-noiser iDataValid.
- ov8Pixel_a, ov8Pixel_b, ov8Pixel_c  out  8 each  top row, left to right.
- ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e  out  8 each  middle row: left, centre, right.
- ov8Pixel_f, ov8Pixel_g, ov8Pixel_h  out  8 each  bottom row, left to right.
- ov10Row, ov10Col  out  10 each  image coordinates of the centre pixel fij.
- oFrameDone  out  1  one-cycle pulse coincident with the last window of a frame.

## Operation
- Column counter c (0..IMG_WIDTH-1) and row counter r (0..IMG_HEIGHT-1) advance on each accepted pixel. At the end of a row, c wraps to 0 and r increments. After pixel (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0.
- When iSof and iPixelValid are high together, the pixel is (0,0) regardless of the counter values, and the counters restart from that pixel. iSof without iPixelValid is ignored.
- Two line buffers, each IMG_WIDTH x 8 (inferred RAM or registers):
  - LB1 holds row r-1.
  - LB2 holds row r-2.
  - On accepting pixel p at column c: read LB1[c] and LB2[c], write LB2[c] <= LB1[c] and LB1[c] <= p in the same cycle. The read must return the old data.
- Window registers form a 3x3 array. On each accept, the array shifts left one column and the new right column is loaded with {LB2[c], LB1[c], p} (top, middle, bottom).
- A window is emitted when the accepted pixel has r >= 2 and c >= 2. The centre is then (r-1, c-1), so centres cover rows 1..IMG_HEIGHT-2 and columns 1..IMG_WIDTH-2.
- There are no border windows: each frame produces exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows. The de-noiser passes border pixels through elsewhere.
- Window columns that straddle a row boundary (c < 2) are never flagged valid.
- oFrameDone is asserted with the window whose input pixel was (IMG_HEIGHT-1, IMG_WIDTH-1).

## Timing
- All outputs are registered.
- Latency: oDataValid and the window are presented one cycle after the accepting edge of the completing pixel.
- Throughput: one window per cycle at full input rate.
- When iPixelValid is low, window registers, coordinates and counters hold, and oDataValid and oFrameDone go low the next cycle. Gaps of any length are legal, including mid-row and at row ends.
- Reset (asynchronous assert, synchronous deassert is the system's responsibility):
  - All outputs are 0, including every ov8Pixel_*, ov10Row, ov10Col, oDataValid and oFrameDone.
  - Counters are 0.
  - Line buffer contents are don't-care, because they are fully rewritten before any use.
- Reset mid-frame: the current frame is abandoned. The next accepted pixel is treated as (0,0) even without iSof.
- iSof mid-frame: same as reset for the counters only. No window is emitted until r >= 2 and c >= 2 of the new frame. Stale line-buffer data is never exposed.
- Back-to-back frames need no idle cycle. The first pixel of frame N+1 may follow the last pixel of frame N directly.

## Test plan
- IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = 10*row + col, continuous valid with iSof on the first pixel -> exactly 6 windows, in order centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3). First window: a=0, b=1, c=2, d=10, fij=11, e=12, f=20, g=21, h=22. oFrameDone is high only on the (2,3) window.
- Same frame with iPixelValid deasserted for 3 cycles before every third pixel -> identical window sequence and values. oDataValid is never high during gaps and outputs hold their values.
- Two frames back-to-back, the second with value = 100 + 10*row + col -> 12 windows, 2 oFrameDone pulses. The first window of frame 2 is centre (1,1) with fij=111 and contains no frame-1 values.
- Assert iRst for 1 cycle mid-row 2 of a frame, then restart the stream without iSof -> all outputs read 0 during reset. The next 6 windows match the first scenario.
- iSof asserted at pixel (2,1) of a running frame -> no window until the new (2,2) pixel. The windows that follow contain only post-iSof data.
- IMG_WIDTH=3, IMG_HEIGHT=3 corner case -> a single window, centre (1,1), with oFrameDone asserted on the same cycle.
